// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller driving an external 1-cycle-latency memory.
// Optional almost_full/almost_empty flags are built when ALMOST_FLAGS_EN is defined.
module fifo_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 6,
    parameter int AF_TH     = (2 ** ADDR_BITS) - 4,
    parameter int AE_TH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    output logic                 write,
    output logic [ADDR_BITS-1:0] addr_write,
    output logic                 read,
    output logic [ADDR_BITS-1:0] addr_read,
    output logic                 data_valid,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
`ifdef ALMOST_FLAGS_EN
    output logic                 almost_full,
    output logic                 almost_empty,
`endif
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_NORMAL = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;

    localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

    logic [ADDR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0] count_d;
    logic [1:0]         state_q, state_d;
    logic               data_valid_q, data_valid_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    assign full       = (state_q == S_FULL);
    assign empty      = (state_q == S_EMPTY);
    assign count      = wr_ptr_q - rd_ptr_q;
    assign addr_write = wr_ptr_q[ADDR_BITS-1:0];
    assign addr_read  = rd_ptr_q[ADDR_BITS-1:0];
    assign data_valid = data_valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

    // Acceptance uses only registered flags, so a pop never frees room for a same-cycle push.
    always_comb begin
        write        = push & ~full & ~reset;
        read         = pop & ~empty & ~reset;
        wr_ptr_d     = wr_ptr_q + {{ADDR_BITS{1'b0}}, write};
        rd_ptr_d     = rd_ptr_q + {{ADDR_BITS{1'b0}}, read};
        count_d      = wr_ptr_d - rd_ptr_d;
        data_valid_d = read;
        overflow_d   = push & full;
        underflow_d  = pop & empty;
        state_d      = state_q;
        case (state_q)
            S_EMPTY: begin
                if (write && !read) state_d = S_NORMAL;
            end
            S_NORMAL: begin
                if (count_d == '0)            state_d = S_EMPTY;
                else if (count_d == DEPTH_CNT) state_d = S_FULL;
            end
            S_FULL: begin
                if (read) state_d = S_NORMAL;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= S_EMPTY;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

`ifdef ALMOST_FLAGS_EN
    localparam logic [ADDR_BITS:0] AF_LVL = AF_TH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] AE_LVL = AE_TH[ADDR_BITS:0];

    logic almost_full_q, almost_full_d;
    logic almost_empty_q, almost_empty_d;

    always_comb begin
        almost_full_d  = (count_d >= AF_LVL);
        almost_empty_d = (count_d <= AE_LVL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (ADDR_BITS=6): reference count/pointer model plus
// a queue of expected data_valid values pushed when a read is issued.
module tb_fifo_ctrl;

    localparam int AB    = 6;
    localparam int DEPTH = 2 ** AB;

    logic          clk;
    logic          reset;
    logic          push;
    logic          pop;
    logic          write;
    logic [AB-1:0] addr_write;
    logic          read;
    logic [AB-1:0] addr_read;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic [AB:0]   count;
    logic          overflow;
    logic          underflow;
`ifdef ALMOST_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    fifo_ctrl #(.DATA_BITS(8), .ADDR_BITS(AB)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .write        (write),
        .addr_write   (addr_write),
        .read         (read),
        .addr_read    (addr_read),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .count        (count),
`ifdef ALMOST_FLAGS_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned wr_m  = 0;
    int unsigned rd_m  = 0;
    int unsigned cnt_m = 0;
    bit          ovf_m = 0;
    bit          udf_m = 0;
    bit          dv_exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, clock, check registered outputs.
    task automatic do_step(input bit rst, input bit p, input bit q);
        bit exp_w;
        bit exp_r;
        bit full_m;
        bit empty_m;
        bit dv_e;
        reset = rst;
        push  = p;
        pop   = q;
        full_m  = (cnt_m == DEPTH);
        empty_m = (cnt_m == 0);
        exp_w = !rst && p && !full_m;
        exp_r = !rst && q && !empty_m;
        #1;
        check("write", {31'd0, write}, {31'd0, exp_w});
        check("read", {31'd0, read}, {31'd0, exp_r});
        check("addr_write_pre", {26'd0, addr_write}, wr_m % DEPTH);
        check("addr_read_pre", {26'd0, addr_read}, rd_m % DEPTH);
        dv_exp_q.push_back(exp_r);
        @(posedge clk);
        #1;
        if (rst) begin
            wr_m = 0; rd_m = 0; ovf_m = 0; udf_m = 0;
        end else begin
            ovf_m = p && full_m;
            udf_m = q && empty_m;
            wr_m  = (wr_m + (exp_w ? 1 : 0)) % (2 * DEPTH);
            rd_m  = (rd_m + (exp_r ? 1 : 0)) % (2 * DEPTH);
        end
        cnt_m = (wr_m + 2 * DEPTH - rd_m) % (2 * DEPTH);
        if (dv_exp_q.size() == 0) begin
            check("dv_queue_empty", 32'd1, 32'd0);
        end else begin
            dv_e = dv_exp_q.pop_front();
            check("data_valid", {31'd0, data_valid}, {31'd0, dv_e && !rst});
        end
        check("count", {25'd0, count}, cnt_m);
        check("full", {31'd0, full}, {31'd0, cnt_m == DEPTH});
        check("empty", {31'd0, empty}, {31'd0, cnt_m == 0});
        check("addr_write", {26'd0, addr_write}, wr_m % DEPTH);
        check("addr_read", {26'd0, addr_read}, rd_m % DEPTH);
        check("overflow", {31'd0, overflow}, {31'd0, ovf_m});
        check("underflow", {31'd0, underflow}, {31'd0, udf_m});
`ifdef ALMOST_FLAGS_EN
        check("almost_full", {31'd0, almost_full}, {31'd0, cnt_m >= DEPTH - 4});
        check("almost_empty", {31'd0, almost_empty}, {31'd0, cnt_m <= 4});
`endif
    endtask

    initial begin
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        @(posedge clk);
        #1;
        // Reset with both requests asserted: write/read must stay low.
        do_step(1, 1, 1);
        do_step(0, 1, 0);
        do_step(0, 0, 1);
        do_step(0, 0, 0);
        do_step(0, 0, 1);
        do_step(0, 0, 0);
        // Fill to full, then a rejected push.
        repeat (DEPTH) do_step(0, 1, 0);
        do_step(0, 1, 0);
        do_step(0, 0, 0);
        do_step(0, 1, 1);
        repeat (53) do_step(0, 0, 1);
        // Steady count of 10 with wrapping addresses.
        repeat (100) do_step(0, 1, 1);
        repeat (8) do_step(0, 0, 1);
        repeat (28) do_step(0, 1, 0);
        // Pop then reset: the pending data_valid shows, the following one is gone.
        do_step(0, 0, 1);
        do_step(1, 0, 1);
        do_step(0, 0, 0);
        do_step(0, 1, 1);
        do_step(0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, width of the memory data word (carried for integration; no data passes through this block).
REQ-002 SHALL have parameter ADDR_BITS, default 6, memory address width; depth DEPTH = 2**ADDR_BITS.
REQ-003 SHALL have parameter AF_TH, default DEPTH-4, almost-full threshold in words.
REQ-004 SHALL have parameter AE_TH, default 4, almost-empty threshold in words.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 Ports SHALL be, in this order:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- push  input  1  requester write request
- pop  input  1  requester read request
- write  output  1  memory write enable
- addr_write  output  ADDR_BITS  memory write address
- read  output  1  memory read enable
- addr_read  output  ADDR_BITS  memory read address
- data_valid  output  1  memory read data valid
- full  output  1  DEPTH words stored
- empty  output  1  zero words stored
- count  output  ADDR_BITS+1  words stored
- almost_full  output  1  count >= AF_TH (ALMOST_FLAGS_EN only)
- almost_empty  output  1  count <= AE_TH (ALMOST_FLAGS_EN only)
- overflow  output  1  one-cycle pulse, push rejected
- underflow  output  1  one-cycle pulse, pop rejected

Function
REQ-007 Internal pointers wr_ptr and rd_ptr SHALL be ADDR_BITS+1 bits wide; addr_write = wr_ptr[ADDR_BITS-1:0] and addr_read = rd_ptr[ADDR_BITS-1:0], both registered.
REQ-008 write SHALL be combinational: push & ~full; read SHALL be combinational: pop & ~empty.
REQ-009 An accepted push SHALL increment wr_ptr at the same rising edge; an accepted pop SHALL increment rd_ptr at the same rising edge; both wrap modulo 2*DEPTH.
REQ-010 data_valid SHALL be read delayed by exactly one clock (memory read latency 1).
REQ-011 full and empty SHALL depend only on registered state: push is rejected while full even if pop is asserted in the same cycle; pop is rejected while empty even if push is asserted.
REQ-012 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-013 A state register SHALL take values S_EMPTY, S_NORMAL, S_FULL: S_EMPTY->S_NORMAL on accepted push alone; S_NORMAL->S_EMPTY when count goes 1->0; S_NORMAL->S_FULL when count goes DEPTH-1->DEPTH; S_FULL->S_NORMAL on accepted pop; otherwise it holds.
REQ-014 empty SHALL be 1 exactly in S_EMPTY, full SHALL be 1 exactly in S_FULL, and count SHALL equal wr_ptr - rd_ptr (ADDR_BITS+1 bits).
REQ-015 overflow SHALL pulse for one cycle, registered, after a cycle with push & full; underflow likewise after a cycle with pop & empty.
REQ-016 Rejected requests SHALL change no pointer, count or state.

Reset
REQ-017 When reset is 1 at a rising edge, the block SHALL set wr_ptr = rd_ptr = 0, count = 0, state S_EMPTY, empty = 1, full = 0, data_valid = 0, overflow = 0, underflow = 0, almost_empty = 1, almost_full = 0.
REQ-018 While reset is 1, write and read SHALL be forced to 0 regardless of push and pop.
REQ-019 Reset asserted mid-operation SHALL discard all stored words; a data_valid that would fall in the cycle after reset SHALL be suppressed.

Configuration
REQ-020 Macro ALMOST_FLAGS_EN: when defined, the almost_full and almost_empty ports and registered logic SHALL exist, updated on the same edge as count; when undefined, those ports SHALL be absent, AF_TH and AE_TH SHALL be unused, and all other behaviour SHALL be identical.

Verification
REQ-021 After reset, push once -> write=1, addr_write=0 that cycle; next cycle count=1, empty=0, addr_write=1.
REQ-022 Push 64 consecutive cycles (ADDR_BITS=6) -> full=1 after the 64th edge; a 65th push gives write=0, a one-cycle overflow pulse, and count stays 64.
REQ-023 From full, push and pop asserted together -> read=1, write=0; next cycle count=63 and state S_NORMAL.
REQ-024 From empty, pop -> read=0 and an underflow pulse; pop after one push -> read=1, addr_read=0, and data_valid=1 exactly one cycle later.
REQ-025 With count=10, push and pop asserted together for 100 cycles -> count stays 10 and addr_write wraps 63->0 without a flag change.
REQ-026 With ALMOST_FLAGS_EN defined, fill to 60 -> almost_full=1; drain to 4 -> almost_empty=1; reset at count=30 -> count=0 and empty=1 on the next cycle.
